// File: rtl/field_seq_pkg.sv
// Shared types and field helpers for the byte field sequencer.
// Build option: define FIELD_SKIP_ZERO_EN to drop zero-valued fields from the beat stream.
package field_seq_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned FLD_W  = 4;

`ifdef FIELD_SKIP_ZERO_EN
    localparam bit SKIP_ZERO = 1'b1;
`else
    localparam bit SKIP_ZERO = 1'b0;
`endif

    typedef enum logic [1:0] {FLD_HI, FLD_MID, FLD_B1, FLD_B0} fld_idx_t;
    typedef enum logic [0:0] {IDLE, EMIT} state_t;

    // Field value for a given index, LSB-aligned with zero upper bits.
    function automatic logic [FLD_W-1:0] fld_extract(input logic [BYTE_W-1:0] b, input fld_idx_t idx);
        logic [FLD_W-1:0] v;
        case (idx)
            FLD_HI:  v = b[7:4];
            FLD_MID: v = {2'b00, b[3:2]};
            FLD_B1:  v = {3'b000, b[1]};
            default: v = {3'b000, b[0]};
        endcase
        return v;
    endfunction

    // True when some field after idx carries a non-zero value.
    function automatic logic later_nonzero(input logic [BYTE_W-1:0] b, input fld_idx_t idx);
        logic any;
        any = 1'b0;
        for (int unsigned j = 0; j < 4; j++) begin
            if (j > 32'(idx) && fld_extract(b, fld_idx_t'(j[1:0])) != '0)
                any = 1'b1;
        end
        return any;
    endfunction

    // Field following idx in emission order.
    function automatic fld_idx_t next_idx(input logic [BYTE_W-1:0] b, input fld_idx_t idx);
        fld_idx_t nxt;
        logic     found;
        nxt   = idx;
        found = 1'b0;
        if (!SKIP_ZERO) begin
            if (idx != FLD_B0)
                nxt = fld_idx_t'(idx + 2'd1);
        end else begin
            for (int unsigned j = 0; j < 4; j++) begin
                if (!found && j > 32'(idx) && fld_extract(b, fld_idx_t'(j[1:0])) != '0) begin
                    nxt   = fld_idx_t'(j[1:0]);
                    found = 1'b1;
                end
            end
            // An all-zero tail still terminates on the final field.
            if (!found)
                nxt = FLD_B0;
        end
        return nxt;
    endfunction

    // True when idx is the final beat of the byte.
    function automatic logic idx_is_last(input logic [BYTE_W-1:0] b, input fld_idx_t idx);
        if (SKIP_ZERO)
            return !later_nonzero(b, idx);
        return idx == FLD_B0;
    endfunction

    // Index of the first beat emitted for a freshly captured byte.
    function automatic fld_idx_t first_idx(input logic [BYTE_W-1:0] b);
        if (SKIP_ZERO && fld_extract(b, FLD_HI) == '0)
            return next_idx(b, FLD_HI);
        return FLD_HI;
    endfunction

endpackage

// File: rtl/field_rr_arbiter.sv
// Round-robin arbiter: scans from ptr upward (modulo NUM_REQ) and grants the first valid request.
module field_rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned SRC_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    input  logic               accept,
    output logic [NUM_REQ-1:0] grant,
    output logic [SRC_W-1:0]   winner
);

    // Rotating priority scan; nothing is granted while accept is low.
    always_comb begin
        logic        found;
        int unsigned pos;
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        pos    = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            pos = (32'(ptr) + off) % NUM_REQ;
            if (accept && !found && req[pos]) begin
                grant[pos] = 1'b1;
                winner     = SRC_W'(pos);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/field_sequencer.sv
// Shares one byte field-splitting path between NUM_REQ requesters; emits [7:4],[3:2],[1],[0]
// as 4-bit valid/ready beats. Build option: FIELD_SKIP_ZERO_EN (see field_seq_pkg).
module field_sequencer
    import field_seq_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [8*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  fld_valid,
    input  logic                  fld_ready,
    output logic [3:0]            fld_data,
    output logic [1:0]            fld_idx,
    output logic [SRC_W-1:0]      fld_src,
    output logic                  fld_last,
    output logic                  busy
);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_EMIT = EMIT;

    logic [0:0]         state_q;
    logic [SRC_W-1:0]   ptr_q;
    logic [SRC_W-1:0]   src_q;
    logic [BYTE_W-1:0]  byte_q;
    fld_idx_t           idx_q;

    logic [NUM_REQ-1:0] grant;
    logic [SRC_W-1:0]   winner;
    logic               take;
    logic [BYTE_W-1:0]  sel_byte;
    logic               cur_last;

    field_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .SRC_W   (SRC_W)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr_q),
        .accept (state_q == ST_IDLE),
        .grant  (grant),
        .winner (winner)
    );

    assign req_ready = grant;
    assign take      = |(req_valid & grant);
    assign sel_byte  = req_data[32'(winner)*BYTE_W +: BYTE_W];
    assign cur_last  = idx_is_last(byte_q, idx_q);

    assign busy      = (state_q == ST_EMIT);
    assign fld_valid = busy;
    assign fld_data  = busy ? fld_extract(byte_q, idx_q) : '0;
    assign fld_idx   = busy ? 2'(idx_q) : 2'b00;
    assign fld_src   = busy ? src_q : '0;
    assign fld_last  = busy & cur_last;

    // Accept one byte in IDLE, then step through its fields on each completed beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            src_q   <= '0;
            byte_q  <= '0;
            idx_q   <= FLD_HI;
        end else if (state_q == ST_IDLE) begin
            if (take) begin
                byte_q  <= sel_byte;
                src_q   <= winner;
                ptr_q   <= (32'(winner) == NUM_REQ - 1) ? '0 : winner + SRC_W'(1);
                idx_q   <= first_idx(sel_byte);
                state_q <= ST_EMIT;
            end
        end else begin
            if (fld_ready) begin
                if (cur_last)
                    state_q <= ST_IDLE;
                else
                    idx_q <= next_idx(byte_q, idx_q);
            end
        end
    end

endmodule
